// File: rtl/axis_frame_fifo_pkg.sv
// axis_frame_fifo_pkg: shared AXI-Stream FIFO definitions.
// Holds the pointer sizing helper and the frame commit events.
package axis_frame_fifo_pkg;

  // Two sideband bits ride with each beat: {tuser, tlast}.
  localparam int SIDE_W = 2;

  // What happened to the frame whose last beat came in this cycle.
  typedef enum logic [1:0] {
    EV_NONE,
    EV_GOOD,
    EV_BAD,
    EV_OVF
  } frame_ev_t;

  // Pointers carry one extra wrap bit so that full and empty
  // can be told apart.
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/axis_frame_fifo_if.sv
// axis_frame_fifo_if: AXI-Stream beat bundle.
// The master drives tdata/tvalid/tlast/tuser. The slave drives tready.
interface axis_frame_fifo_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/axis_frame_fifo_ram.sv
// axis_frame_fifo_ram: simple dual-port RAM, one write port, one sync read.
// Ports: clk, rst_n (clears only the read register), we/wa/wd, re/ra/rd.
module axis_frame_fifo_ram #(
  parameter int WIDTH      = 10,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [WIDTH-1:0]      wd,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [WIDTH-1:0]      rd
);

  logic [WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  // The read register doubles as the FIFO output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd <= '0;
    end else if (re) begin
      rd <= mem[ra];
    end
  end

endmodule

// File: rtl/axis_frame_fifo.sv
// axis_frame_fifo: single-clock AXI-Stream FIFO, optional store-and-forward.
// Ports: clk, rst_n, input_axis (slave), output_axis (master), status_*.
module axis_frame_fifo
  import axis_frame_fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int USER_ENABLE    = 1,
  parameter int FRAME_MODE     = 0,
  parameter int DROP_BAD_FRAME = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axis_frame_fifo_if.slave      input_axis,
  axis_frame_fifo_if.master     output_axis,
  output logic [ADDR_WIDTH:0]   status_count,
  output logic                  status_overflow,
  output logic                  status_bad_frame,
  output logic                  status_good_frame
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam int RW = DATA_WIDTH + SIDE_W;
  localparam logic [PW-1:0] DEPTH = PW'(1 << ADDR_WIDTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_commit;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_nx;
  logic [PW-1:0] commit_nx;
  logic [PW-1:0] used;
  logic          drop;
  logic          drop_nx;
  logic          drop_now;
  logic          full;
  logic          empty;
  logic          accept;
  logic          bad_drop;
  logic          user_in;
  logic          ram_we;
  logic          rd_en;
  logic          out_valid;
  logic [RW-1:0] ram_wd;
  logic [RW-1:0] ram_rd;
  frame_ev_t     ev;

  assign used  = wr_ptr - rd_ptr;
  assign full  = (used == DEPTH);
  assign empty = (rd_ptr ==
                  ((FRAME_MODE != 0) ? wr_commit : wr_ptr));

  // A beat offered while full starts (or continues) a drop at once,
  // so the oversize frame is swallowed without stalling the source.
  assign drop_now = (FRAME_MODE != 0) &&
                    (drop || (input_axis.tvalid && full));

  assign input_axis.tready = rst_n && (!full || drop_now);
  assign accept = input_axis.tvalid && input_axis.tready;

  assign user_in  = (USER_ENABLE != 0) && input_axis.tuser;
  assign bad_drop = (DROP_BAD_FRAME != 0) && input_axis.tuser;
  assign ram_wd   = {user_in, input_axis.tlast, input_axis.tdata};

  always_comb begin
    wr_ptr_nx = wr_ptr;
    commit_nx = wr_commit;
    drop_nx   = drop;
    ev        = EV_NONE;
    ram_we    = 1'b0;
    if (FRAME_MODE == 0) begin
      ram_we = accept;
      if (accept) begin
        wr_ptr_nx = wr_ptr + 1'b1;
      end
    end else if (accept && drop_now) begin
      // Discard the partial frame; stay in drop until its tlast.
      wr_ptr_nx = wr_commit;
      drop_nx   = !input_axis.tlast;
      if (input_axis.tlast) begin
        ev = EV_OVF;
      end
    end else if (accept) begin
      ram_we = 1'b1;
      if (!input_axis.tlast) begin
        wr_ptr_nx = wr_ptr + 1'b1;
      end else if (bad_drop) begin
        wr_ptr_nx = wr_commit;
        ev        = EV_BAD;
      end else begin
        wr_ptr_nx = wr_ptr + 1'b1;
        commit_nx = wr_ptr + 1'b1;
        ev        = EV_GOOD;
      end
    end
  end

  assign rd_en = !empty && (!out_valid || output_axis.tready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr            <= '0;
      wr_commit         <= '0;
      rd_ptr            <= '0;
      drop              <= 1'b0;
      out_valid         <= 1'b0;
      status_overflow   <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_good_frame <= 1'b0;
    end else begin
      wr_ptr            <= wr_ptr_nx;
      wr_commit         <= commit_nx;
      drop              <= drop_nx;
      status_overflow   <= (ev == EV_OVF);
      status_bad_frame  <= (ev == EV_BAD);
      status_good_frame <= (ev == EV_GOOD);
      if (rd_en) begin
        rd_ptr    <= rd_ptr + 1'b1;
        out_valid <= 1'b1;
      end else if (output_axis.tready) begin
        out_valid <= 1'b0;
      end
    end
  end

  axis_frame_fifo_ram #(
    .WIDTH      (RW),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .wa    (wr_ptr[ADDR_WIDTH-1:0]),
    .wd    (ram_wd),
    .re    (rd_en),
    .ra    (rd_ptr[ADDR_WIDTH-1:0]),
    .rd    (ram_rd)
  );

  assign output_axis.tvalid = out_valid;
  assign output_axis.tdata  = ram_rd[DATA_WIDTH-1:0];
  assign output_axis.tlast  = ram_rd[DATA_WIDTH];
  assign output_axis.tuser  = (USER_ENABLE != 0) && ram_rd[DATA_WIDTH+1];

  assign status_count = used;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// tb_axis_frame_fifo: directed plus random checks of axis_frame_fifo.
// DUT 0 plain, DUT 1 frame mode with bad drop, DUT 2 small frame mode.
module tb_axis_frame_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axis_frame_fifo_if #(.DATA_WIDTH(8)) in_if  [3] ();
  axis_frame_fifo_if #(.DATA_WIDTH(8)) out_if [3] ();

  logic [7:0] d_data   [3];
  logic       d_valid  [3];
  logic       d_last   [3];
  logic       d_user   [3];
  logic       d_oready [3];
  logic       tready_w [3];
  logic       o_valid_w[3];
  logic [9:0] o_beat_w [3];
  logic [4:0] cnt_w    [3];
  logic       good_w   [3];
  logic       bad_w    [3];
  logic       ovf_w    [3];
  logic [4:0] cnt0;
  logic [4:0] cnt1;
  logic [3:0] cnt2;

  for (genvar g = 0; g < 3; g++) begin : g_conn
    assign in_if[g].tdata   = d_data[g];
    assign in_if[g].tvalid  = d_valid[g];
    assign in_if[g].tlast   = d_last[g];
    assign in_if[g].tuser   = d_user[g];
    assign out_if[g].tready = d_oready[g];
    assign tready_w[g]      = in_if[g].tready;
    assign o_valid_w[g]     = out_if[g].tvalid;
    assign o_beat_w[g]      = {out_if[g].tuser, out_if[g].tlast,
                               out_if[g].tdata};
  end

  assign cnt_w[0] = cnt0;
  assign cnt_w[1] = cnt1;
  assign cnt_w[2] = {1'b0, cnt2};

  axis_frame_fifo #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .USER_ENABLE(1),
    .FRAME_MODE(0), .DROP_BAD_FRAME(0)
  ) u_plain (
    .clk(clk), .rst_n(rst_n),
    .input_axis(in_if[0]), .output_axis(out_if[0]),
    .status_count(cnt0), .status_overflow(ovf_w[0]),
    .status_bad_frame(bad_w[0]), .status_good_frame(good_w[0])
  );

  axis_frame_fifo #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .USER_ENABLE(1),
    .FRAME_MODE(1), .DROP_BAD_FRAME(1)
  ) u_frame (
    .clk(clk), .rst_n(rst_n),
    .input_axis(in_if[1]), .output_axis(out_if[1]),
    .status_count(cnt1), .status_overflow(ovf_w[1]),
    .status_bad_frame(bad_w[1]), .status_good_frame(good_w[1])
  );

  axis_frame_fifo #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .USER_ENABLE(1),
    .FRAME_MODE(1), .DROP_BAD_FRAME(0)
  ) u_small (
    .clk(clk), .rst_n(rst_n),
    .input_axis(in_if[2]), .output_axis(out_if[2]),
    .status_count(cnt2), .status_overflow(ovf_w[2]),
    .status_bad_frame(bad_w[2]), .status_good_frame(good_w[2])
  );

  int depth_of [3] = '{16, 16, 8};
  bit frame_of [3] = '{1'b0, 1'b1, 1'b1};
  bit dbad_of  [3] = '{1'b0, 1'b1, 1'b0};

  int n_checks = 0;
  int n_errors = 0;
  int n_acc = 0;
  int exp_good, exp_bad, exp_ovf;
  int obs_good, obs_bad, obs_ovf;
  logic [9:0] src_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] frm_q[$];
  bit stall_prev = 1'b0;
  logic [9:0] held;
  int last_d = -1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain mode queues every accepted beat; frame mode
  // releases a whole frame only if it fits and is not a dropped bad one.
  task automatic model_accept(input int d, input logic [9:0] b);
    if (!frame_of[d]) begin
      exp_q.push_back(b);
    end else begin
      frm_q.push_back(b);
      if (b[8]) begin
        if (frm_q.size() > depth_of[d]) exp_ovf++;
        else if (b[9] && dbad_of[d]) exp_bad++;
        else begin
          exp_good++;
          foreach (frm_q[i]) exp_q.push_back(frm_q[i]);
        end
        frm_q.delete();
      end
    end
  endtask

  task automatic step(input int d, input bit ordy, input bit gaps);
    logic [9:0] b;
    logic [9:0] e;
    bit hi;
    bit ho;
    if (d != last_d) stall_prev = 1'b0;
    last_d = d;
    d_oready[d] = ordy;
    b = '0;
    if (src_q.size() != 0 && (!gaps || $urandom_range(3) != 0)) begin
      b = src_q[0];
      d_valid[d] = 1'b1;
      {d_user[d], d_last[d], d_data[d]} = b;
    end else begin
      d_valid[d] = 1'b0;
    end
    #1;
    if (stall_prev) begin
      check("hold_valid", 32'(o_valid_w[d]), 32'd1);
      check("hold_data", 32'(o_beat_w[d]), 32'(held));
    end
    stall_prev = o_valid_w[d] && !ordy;
    held = o_beat_w[d];
    hi = d_valid[d] && tready_w[d];
    ho = o_valid_w[d] && ordy;
    if (ho) begin
      check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat", 32'(o_beat_w[d]), 32'(e));
      end
    end
    if (hi) begin
      void'(src_q.pop_front());
      model_accept(d, b);
      n_acc++;
    end
    tick();
    d_valid[d] = 1'b0;
    if (good_w[d]) obs_good++;
    if (bad_w[d]) obs_bad++;
    if (ovf_w[d]) obs_ovf++;
  endtask

  // mode 0: always ready, 1: ready 1010..., 2: random ready.
  task automatic run(input int d, input int mode, input bit gaps,
                     input int maxc);
    int c;
    bit r;
    c = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && c < maxc) begin
      r = (mode == 0) ? 1'b1 :
          (mode == 1) ? ((c % 2) == 0) : 1'($urandom_range(1));
      step(d, r, gaps);
      c++;
    end
    check("src_done", 32'(src_q.size()), 32'd0);
    check("exp_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clr_events();
    exp_good = 0; exp_bad = 0; exp_ovf = 0;
    obs_good = 0; obs_bad = 0; obs_ovf = 0;
  endtask

  task automatic chk_events(input string tag);
    check({tag, "_good"}, 32'(obs_good), 32'(exp_good));
    check({tag, "_bad"}, 32'(obs_bad), 32'(exp_bad));
    check({tag, "_ovf"}, 32'(obs_ovf), 32'(exp_ovf));
  endtask

  initial begin
    int len;
    int prev;
    bit bad;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_valid[i] = 0; d_data[i] = 0; d_last[i] = 0;
      d_user[i] = 0; d_oready[i] = 0;
    end
    clr_events();

    // Reset stall: beat 01 offered during reset must survive.
    for (int i = 1; i <= 6; i++) src_q.push_back(10'(i));
    for (int c = 0; c < 6; c++) begin
      d_valid[0] = 1'b1;
      d_data[0]  = 8'h01;
      #1;
      check("rst_tready", 32'(tready_w[0]), 32'd0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check("rst_valid", 32'(o_valid_w[i]), 32'd0);
      check("rst_beat", 32'(o_beat_w[i]), 32'd0);
      check("rst_count", 32'(cnt_w[i]), 32'd0);
      check("rst_pulses", 32'({good_w[i], bad_w[i], ovf_w[i]}), 32'd0);
    end
    rst_n = 1'b1;
    run(0, 0, 0, 100);

    // Fill with the sink stalled: 16 in RAM plus one in the output reg.
    n_acc = 0;
    for (int i = 0; i < 18; i++) src_q.push_back(10'($urandom));
    for (int c = 0; c < 30; c++) step(0, 1'b0, 1'b0);
    check("fill_acc", 32'(n_acc), 32'd17);
    check("fill_tready", 32'(tready_w[0]), 32'd0);
    check("fill_count", 32'(cnt_w[0]), 32'd16);
    check("fill_pending", 32'(src_q.size()), 32'd1);
    run(0, 0, 0, 100);
    check("drain_count", 32'(cnt_w[0]), 32'd0);

    // Toggling backpressure, then fully random traffic.
    for (int i = 0; i < 40; i++) src_q.push_back(10'($urandom));
    run(0, 1, 0, 400);
    for (int i = 0; i < 150; i++) src_q.push_back(10'($urandom));
    run(0, 2, 1, 3000);
    check("plain_count", 32'(cnt_w[0]), 32'd0);

    // Store-and-forward: nothing visible until the frame commits.
    clr_events();
    for (int i = 0; i < 4; i++)
      src_q.push_back({1'b0, i == 3, 8'hA0 + 8'(i)});
    for (int c = 0; c < 10 && src_q.size() != 0; c++) begin
      check("f4_novalid", 32'(o_valid_w[1]), 32'd0);
      step(1, 1'b1, 1'b0);
    end
    check("f4_good_now", 32'(good_w[1]), 32'd1);
    check("f4_still_idle", 32'(o_valid_w[1]), 32'd0);
    step(1, 1'b1, 1'b0);
    check("f4_visible", 32'(o_valid_w[1]), 32'd1);
    check("f4_first", 32'(o_beat_w[1]), 32'h0A0);
    run(1, 0, 0, 50);
    chk_events("f4");

    // Bad frame dropped behind a committed good frame.
    clr_events();
    src_q.push_back(10'h011);
    src_q.push_back(10'h112);
    src_q.push_back(10'h0B0);
    src_q.push_back(10'h0B1);
    src_q.push_back(10'h3B2);
    for (int c = 0; c < 20 && src_q.size() != 0; c++)
      step(1, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0);
    check("f5_count", 32'(cnt_w[1]), 32'd1);
    for (int i = 0; i < 3; i++)
      src_q.push_back({1'b0, i == 2, 8'hC0 + 8'(i)});
    run(1, 0, 0, 100);
    chk_events("f5");
    check("f5_bad_once", 32'(obs_bad), 32'd1);

    // Oversize frame on the 8-deep FIFO is swallowed without stalling.
    clr_events();
    for (int i = 0; i < 12; i++)
      src_q.push_back({1'b0, i == 11, 8'h50 + 8'(i)});
    for (int c = 0; c < 12; c++) begin
      prev = n_acc;
      step(2, 1'b1, 1'b0);
      check("f6_tready", 32'(n_acc), 32'(prev + 1));
    end
    step(2, 1'b1, 1'b0);
    step(2, 1'b1, 1'b0);
    check("f6_novalid", 32'(o_valid_w[2]), 32'd0);
    check("f6_count", 32'(cnt_w[2]), 32'd0);
    check("f6_ovf_once", 32'(obs_ovf), 32'd1);
    src_q.push_back(10'h061);
    src_q.push_back(10'h162);
    run(2, 0, 0, 50);
    chk_events("f6");

    // Random frames, each started on an empty FIFO.
    clr_events();
    for (int f = 0; f < 14; f++) begin
      len = $urandom_range(20, 1);
      bad = 1'($urandom_range(1));
      for (int i = 0; i < len; i++) begin
        if (i == len - 1) src_q.push_back({bad, 1'b1, 8'($urandom)});
        else src_q.push_back({1'($urandom), 1'b0, 8'($urandom)});
      end
      run(1, 2, 1, 500);
    end
    chk_events("frnd");
    check("frnd_count", 32'(cnt_w[1]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
